// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-read-port MIPS32 register file.
// Default geometry, ABI register indices and a packed-vector slicing helper.
package regfile_pkg;

   localparam int RF_DW = 32;
   localparam int RF_AW = 5;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_AT   = 1;
   localparam int unsigned REG_V0   = 2;
   localparam int unsigned REG_A0   = 4;
   localparam int unsigned REG_T0   = 8;
   localparam int unsigned REG_S0   = 16;
   localparam int unsigned REG_T8   = 24;
   localparam int unsigned REG_K0   = 26;
   localparam int unsigned REG_GP   = 28;
   localparam int unsigned REG_SP   = 29;
   localparam int unsigned REG_FP   = 30;
   localparam int unsigned REG_RA   = 31;

   // Widest packed vector / field the slicing helper handles (4 ports x 64 bits).
   localparam int SLICE_VEC_W = 256;
   localparam int SLICE_OUT_W = 64;

   typedef logic [RF_AW-1:0] reg_idx_t;

   function automatic logic [SLICE_OUT_W-1:0] port_slice(
      input logic [SLICE_VEC_W-1:0] vec,
      input int unsigned            idx,
      input int unsigned            w
   );
      logic [SLICE_VEC_W-1:0] shifted;
      logic [SLICE_VEC_W-1:0] mask;
      shifted = vec >> (idx * w);
      mask    = ~({SLICE_VEC_W{1'b1}} << w);
      return SLICE_OUT_W'(shifted & mask);
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: read mux, same-cycle write bypass (REGFILE_BYPASS_EN),
// zero-register override and the output data/pending registers.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int AW       = RF_AW,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rd_en,
   input  logic [AW-1:0]          rd_addr,
   input  logic [(2**AW)*DW-1:0]  regs_flat,
   input  logic [(2**AW)-1:0]     pend_vec,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [DW-1:0]          wr_data,
   input  logic                   pend_set,
   input  logic [AW-1:0]          pend_addr,
   output logic [DW-1:0]          rd_data,
   output logic                   rd_pend
);

   logic          is_zero;
   logic [DW-1:0] sel_data;
   logic          sel_pend;
   logic [DW-1:0] rd_data_d;
   logic [DW-1:0] rd_data_q;
   logic          rd_pend_d;
   logic          rd_pend_q;

   assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);

   always_comb begin
      sel_data = regs_flat[int'(rd_addr) * DW +: DW];
      sel_pend = pend_vec[rd_addr];
`ifdef REGFILE_BYPASS_EN
      // A write landing this cycle retires its producer unless a newer one issues now.
      if (wr_en && (wr_addr == rd_addr)) begin
         sel_data = wr_data;
         sel_pend = pend_set && (pend_addr == rd_addr);
      end
`endif
      if (is_zero) begin
         sel_data = '0;
         sel_pend = 1'b0;
      end
   end

`ifndef REGFILE_BYPASS_EN
   logic unused_bypass_inputs;
   assign unused_bypass_inputs = ^{wr_en, wr_addr, wr_data, pend_set, pend_addr};
`endif

   always_comb begin
      rd_data_d = rd_data_q;
      rd_pend_d = rd_pend_q;
      if (rd_en) begin
         rd_data_d = sel_data;
         rd_pend_d = sel_pend;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         rd_data_q <= rd_data_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   assign rd_data = rd_data_q;
   assign rd_pend = rd_pend_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD registered read ports, one writeback port,
// per-register pending scoreboard. Optional same-cycle bypass: REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int AW       = RF_AW,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_RD-1:0]    rd_en,
   input  logic [NUM_RD*AW-1:0] rd_addr,
   output logic [NUM_RD*DW-1:0] rd_data,
   output logic [NUM_RD-1:0]    rd_pend,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [DW-1:0]        wr_data,
   input  logic                 pend_set,
   input  logic [AW-1:0]        pend_addr,
   output logic                 pend_any
);

   localparam int DEPTH = 2**AW;

   logic [DW-1:0]       regs_q [DEPTH];
   logic [DW-1:0]       regs_d [DEPTH];
   logic [DEPTH-1:0]    pend_q;
   logic [DEPTH-1:0]    pend_d;
   logic                pend_any_q;
   logic                pend_any_d;
   logic [DEPTH*DW-1:0] regs_flat;
   logic                wr_ok;
   logic                set_ok;

   assign wr_ok  = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
   assign set_ok = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));

   always_comb begin
      regs_d = regs_q;
      if (wr_ok) begin
         regs_d[wr_addr] = wr_data;
      end
   end

   // Clear before set so a same-cycle reissue to the written register stays pending.
   always_comb begin
      pend_d = pend_q;
      if (wr_en) begin
         pend_d[wr_addr] = 1'b0;
      end
      if (set_ok) begin
         pend_d[pend_addr] = 1'b1;
      end
      pend_any_d = |pend_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         pend_q     <= '0;
         pend_any_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         pend_any_q <= pend_any_d;
      end
   end

   assign pend_any = pend_any_q;

   for (genvar r = 0; r < DEPTH; r++) begin : g_flat
      assign regs_flat[r*DW +: DW] = regs_q[r];
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] port_addr;

      assign port_addr = AW'(port_slice(SLICE_VEC_W'(rd_addr), i, AW));

      regfile_rd_port #(
         .DW       (DW),
         .AW       (AW),
         .ZERO_REG (ZERO_REG)
      ) u_port (
         .clk       (clk),
         .rst_n     (rst_n),
         .rd_en     (rd_en[i]),
         .rd_addr   (port_addr),
         .regs_flat (regs_flat),
         .pend_vec  (pend_q),
         .wr_en     (wr_en),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .pend_set  (pend_set),
         .pend_addr (pend_addr),
         .rd_data   (rd_data[i*DW +: DW]),
         .rd_pend   (rd_pend[i])
      );
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS32 datapath; replaces the fixed 32x32, 2-read register file.
- Adds configurable width, depth and read-port count, and registered reads with 1-cycle latency.
- Adds a per-register pending (scoreboard) bit, so decode can detect load-use hazards.
- Sits between decode (read addresses, issue) and writeback (write port).

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0 and is never written or marked pending.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*DW  packed registered read data.
- rd_pend  out  NUM_RD  registered pending flag, paired with rd_data.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback address.
- wr_data  in  DW  writeback data.
- pend_set  in  1  issue of an instruction that will write pend_addr.
- pend_addr  in  AW  destination register of the issuing instruction.
- pend_any  out  1  OR of all pending bits (drain/flush status).

Behaviour:
- Reset (async, rst_n=0): all registers 0; all pending bits 0; rd_data 0; rd_pend 0; pend_any 0. Reset asserted mid-operation discards any in-flight write and pending state immediately.
- Write: on posedge, if wr_en, reg[wr_addr] <= wr_data. When ZERO_REG=1 and wr_addr==0, the write is ignored.
- Read: on posedge, for each port i with rd_en[i]=1:
  - rd_data_i <= reg[rd_addr_i];
  - rd_pend_i <= pend[rd_addr_i].
- Read latency is 1 cycle. With rd_en[i]=0, port i holds its last rd_data and rd_pend.
- Address 0 with ZERO_REG=1: the read returns 0 and pending 0 regardless of state.
- Same-cycle write and read to the same address: behaviour depends on REGFILE_BYPASS_EN (see Optional Feature).
- Pending bits:
  - pend_set sets pend[pend_addr].
  - wr_en clears pend[wr_addr].
  - Set and clear to the same address in the same cycle: set wins (a newer producer has been issued).
  - pend_set to address 0 with ZERO_REG=1 is ignored.
- pend_any is registered: it is the OR of the pending bits after the update, so it is valid the cycle after the update.
- Multiple read ports addressing the same register return identical data in the same cycle.
- Addresses are always in range, since depth = 2**AW.
- No write-write conflict is possible with a single write port.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read that coincides with wr_en to the same (non-zero) address:
  - captures wr_data, not the old register contents;
  - captures rd_pend = 0, unless pend_set targets that address in the same cycle, in which case rd_pend = 1.
- Not defined: the read captures the pre-write register value and pre-update pending bit. The pipeline must then insert a 1-cycle stall on that hazard.

Decomposition:
- Package regfile_pkg:
  - default DW/AW constants;
  - REG_ZERO=0 and ABI index constants (REG_AT=1, REG_V0=2, REG_A0=4, REG_T0=8, REG_S0=16, REG_T8=24, REG_K0=26, REG_GP=28, REG_SP=29, REG_FP=30, REG_RA=31);
  - helper function to slice packed port vectors.
- Sub-module regfile_rd_port, instantiated NUM_RD times by generate. It contains the per-port read mux, the bypass compare, the zero-register override and the output registers.

Test Plan:
- Reset: rst_n=0 mid-traffic -> rd_data=0, rd_pend=0, pend_any=0 immediately. After release, reads of every address return 0.
- Write then read: write reg5=0xDEADBEEF, then read port0 addr5 and port1 addr5 next cycle -> both return 0xDEADBEEF one cycle later.
- Zero register: write addr0=0xFFFFFFFF, pend_set addr0 -> read addr0 returns 0, rd_pend=0, pend_any stays 0.
- Bypass: reg9=0x11, then same-cycle wr_en addr9=0x22 and read addr9:
  - with REGFILE_BYPASS_EN: read returns 0x22;
  - without: read returns 0x11, and 0x22 on the next read.
- Scoreboard: pend_set addr31 -> read addr31 gives rd_pend=1 and pend_any=1. wr_en addr31 -> next read gives rd_pend=0 and pend_any=0. Simultaneous pend_set and wr_en addr31 -> pending remains 1.
- Hold: write reg3=7, read addr3, then deassert rd_en and write reg3=9 -> rd_data holds 7 until rd_en is re-asserted.
